sw_event_counter: RTL and testbench
===================================

Name: sw_event_counter

Overview:
- Parametrised successor to the board-level switch/counter/display top.
- Samples a switch bank and detects a rising "event" when the count of set switches strictly exceeds a runtime threshold.
- Counts events up or down over DIGITS hex digits, with wrap or saturate mode and a sticky overflow flag.
- Drives DIGITS 7-segment displays (active-low) and mirrors the switches to the LEDs through an enabled register.

Parameters:
SW_W, 10, switch/LED bank width (1..15)
DIGITS, 2, hex digits displayed; counter width CW = 4*DIGITS (1..8)
THRESH_W, 4, width of thresh_i; must hold SW_W
SATURATE, 0, 0 = counter wraps at limits, 1 = counter holds at limits

Ports:
clk50_i  in  1  system clock, all logic on rising edge
arst_i  in  1  reset, synchronous, active-high
en_i  in  1  count/LED-load enable, active-high
clr_i  in  1  synchronous clear of counter and ovf_o
dir_i  in  1  0 = count up, 1 = count down
sw_i  in  SW_W  switch bank
thresh_i  in  THRESH_W  event threshold
ledr_o  out  SW_W  registered switch copy
count_o  out  CW  event counter value
hex_o  out  7*DIGITS  segments; digit k = hex_o[7k+6:7k] shows count_o[4k+3:4k]
event_o  out  1  one-cycle pulse per counted event
ovf_o  out  1  sticky over/underflow flag

Behaviour:
- Reset (arst_i=1 at a clock edge) has priority over everything and sets:
  - sw_q=0, lvl_q=0, count_o=0, event_o=0, ovf_o=0, ledr_o=0
  - every hex_o digit = 7'b1000000 ("0")
- sw_q <= sw_i every cycle, regardless of en_i.
- ledr_o <= sw_i when en_i=1; otherwise holds.
- pop = number of ones in sw_q, width clog2(SW_W+1). Comparison is unsigned: lvl = (pop > thresh_i). Equality is not an event.
- lvl_q <= lvl every cycle, regardless of en_i. rise = lvl & ~lvl_q.
- Counting, priority clr_i > (rise & en_i):
  - clr_i=1: count_o <= 0, ovf_o <= 0, event_o <= 0.
  - rise & en_i:
    - event_o <= 1.
    - dir_i=0: count_o+1. At 2^CW-1 it wraps to 0 (SATURATE=0) or holds (SATURATE=1); ovf_o <= 1 in both modes.
    - dir_i=1: count_o-1. At 0 it wraps to 2^CW-1 or holds; ovf_o <= 1.
  - otherwise: event_o <= 0, count holds.
- A rise while en_i=0 is lost, not deferred.
- A threshold change that makes lvl go 0->1 counts as an event.
- ovf_o clears only on clr_i or reset.
- Latency, with sw_i changed before edge N:
  - sw_q valid after N.
  - count_o/event_o update after N+1.
  - hex_o updates after N+2 (registered decode of count_o).
- Segment codes, bit order {g,f,e,d,c,b,a}, active-low:
  - 0:1000000 1:1111001 2:0100100 3:0110000
  - 4:0011001 5:0010010 6:0000010 7:1111000
  - 8:0000000 9:0010000 A:0001000 b:0000011
  - C:1000110 d:0100001 E:0000110 F:0001110
- Reset release with switches held above threshold: lvl_q restarts at 0, so one event is counted 2 cycles after release if en_i=1. This is intended.
- No state other than the above. Holding lvl high produces exactly one event.

Test Plan:
- Reset: assert arst_i 2 cycles with sw_i=10'h3FF -> all outputs 0, hex_o=14'h2040 (DIGITS=2). Release with en_i=1 and thresh_i=3 -> event_o pulses once, count_o=1, then hex_o=14'h2079.
- Threshold boundary: thresh_i=3. Set sw_i=10'h007 (pop 3) -> no event. Set sw_i=10'h00F -> event after 2 edges, count_o=1. Hold 20 cycles -> count stays 1. Drop to 10'h001, then back to 10'h00F -> count_o=2.
- Enable gating: en_i=0, toggle sw_i 10'h000 <-> 10'h3FF 5 times -> count_o unchanged, ledr_o holds. Set en_i=1 and repeat -> count_o +5, ledr_o follows sw_i.
- Wrap vs saturate: preload count_o=8'hFF via events, dir_i=0, one more event. SATURATE=0 -> count_o=8'h00, ovf_o=1. SATURATE=1 -> count_o=8'hFF, ovf_o=1. Then dir_i=1 from 0 -> 8'hFF (wrap) or 8'h00 (sat).
- Clear priority: clr_i=1 in the same cycle as a rise with en_i=1 -> count_o=0, ovf_o=0, event_o=0. The next event gives count_o=1.
- Digit mapping: drive count_o to 8'hA5 -> hex_o[6:0]=0010010, hex_o[13:7]=0001000, one cycle after count_o settles.

Source files
------------

// File: rtl/sw_event_counter.sv
// sw_event_counter: samples a switch bank, counts rising "more switches set
// than the threshold" events up or down over DIGITS hex digits, shows the
// count on active-low 7-segment displays and mirrors the switches to LEDs.
module sw_event_counter #(
    parameter int SW_W     = 10,
    parameter int DIGITS   = 2,
    parameter int THRESH_W = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk50_i,
    input  logic                  arst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  dir_i,
    input  logic [SW_W-1:0]       sw_i,
    input  logic [THRESH_W-1:0]   thresh_i,
    output logic [SW_W-1:0]       ledr_o,
    output logic [4*DIGITS-1:0]   count_o,
    output logic [7*DIGITS-1:0]   hex_o,
    output logic                  event_o,
    output logic                  ovf_o
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = $clog2(SW_W + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [6:0]    SEG_ZERO = 7'b1000000;

    logic [SW_W-1:0] sw_q;
    logic            lvl_q;
    logic [PW-1:0]   pop;
    logic            lvl;
    logic            rise;
    logic            at_limit;
    logic [CW-1:0]   stepped;

    // Hex digit to active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Population count of the sampled switches and threshold/edge detection.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latch can be inferred.
        pop = '0;
        for (int i = 0; i < SW_W; i++) begin
            pop = pop + PW'(sw_q[i]);
        end
        lvl  = (32'(pop) > 32'(thresh_i));
        rise = lvl & ~lvl_q;
    end

    // Next counter value one step in the selected direction, and whether that step crosses a limit.
    always_comb begin
        at_limit = dir_i ? (count_o == '0) : (count_o == CNT_MAX);
        stepped  = dir_i ? (count_o - CW'(1)) : (count_o + CW'(1));
    end

    // Input sampling: switch and level history run every cycle, LEDs load only when enabled.
    always_ff @(posedge clk50_i) begin
        // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values, independent of statement order.
        if (arst_i) begin
            sw_q   <= '0;
            lvl_q  <= 1'b0;
            ledr_o <= '0;
        end else begin
            sw_q  <= sw_i;
            lvl_q <= lvl;
            if (en_i) begin
                ledr_o <= sw_i;
            end
        end
    end

    // Event counter with clear priority, wrap/saturate at the limits and a sticky overflow flag.
    always_ff @(posedge clk50_i) begin
        if (arst_i) begin
            count_o <= '0;
            event_o <= 1'b0;
            ovf_o   <= 1'b0;
        end else if (clr_i) begin
            count_o <= '0;
            event_o <= 1'b0;
            ovf_o   <= 1'b0;
        end else if (rise && en_i) begin
            event_o <= 1'b1;
            if (at_limit) begin
                ovf_o <= 1'b1;
            end
            if (!(at_limit && SATURATE)) begin
                count_o <= stepped;
            end
        end else begin
            event_o <= 1'b0;
        end
    end

    // Registered segment decode, one cycle behind count_o.
    always_ff @(posedge clk50_i) begin
        if (arst_i) begin
            hex_o <= {DIGITS{SEG_ZERO}};
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                hex_o[7*k +: 7] <= seg7(count_o[4*k +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_sw_event_counter.sv
// Testbench for sw_event_counter: wrap and saturate instances side by side,
// a vector table for the threshold boundary, hand sequences for the corner
// cases and a randomized run against a behavioural model.
module tb_sw_event_counter;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic       dir = 1'b0;
    logic [9:0] sw = 10'h3FF;
    logic [3:0] thr = 4'd3;

    logic [9:0]  ledr [2];
    logic [7:0]  cnt  [2];
    logic [13:0] hex  [2];
    logic        evt  [2];
    logic        ovf  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state (index 0 = wrapping instance, 1 = saturating instance).
    int         m_pop;
    bit         m_lvlq;
    bit         m_evt;
    logic [9:0] m_led;
    int         m_cnt    [2];
    bit         m_ovf    [2];
    int         m_hexcnt [2];

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [9:0] sw;
        logic [3:0] thr;
        logic       en;
        logic       clr;
        int         exp_cnt;
        logic       exp_evt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sw_event_counter #(.SW_W(10), .DIGITS(2), .THRESH_W(4), .SATURATE(1'b0)) u_wrap (
        .clk50_i(clk), .arst_i(arst), .en_i(en), .clr_i(clr), .dir_i(dir),
        .sw_i(sw), .thresh_i(thr), .ledr_o(ledr[0]), .count_o(cnt[0]),
        .hex_o(hex[0]), .event_o(evt[0]), .ovf_o(ovf[0])
    );

    sw_event_counter #(.SW_W(10), .DIGITS(2), .THRESH_W(4), .SATURATE(1'b1)) u_sat (
        .clk50_i(clk), .arst_i(arst), .en_i(en), .clr_i(clr), .dir_i(dir),
        .sw_i(sw), .thresh_i(thr), .ledr_o(ledr[1]), .count_o(cnt[1]),
        .hex_o(hex[1]), .event_o(evt[1]), .ovf_o(ovf[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] s, input logic c, input int ec, input logic ee);
        vec_t v;
        v.sw = s; v.thr = 4'd3; v.en = 1'b1; v.clr = c; v.exp_cnt = ec; v.exp_evt = ee;
        return v;
    endfunction

    // Model update for one rising edge, from the rules: event = level rises while enabled.
    task automatic model_step();
        bit lvl;
        bit rise;
        int nxt;
        if (arst) begin
            m_pop = 0; m_lvlq = 0; m_evt = 0; m_led = '0;
            for (int d = 0; d < 2; d++) begin
                m_cnt[d] = 0; m_ovf[d] = 0; m_hexcnt[d] = 0;
            end
        end else begin
            lvl  = (m_pop > int'(thr));
            rise = lvl && !m_lvlq;
            for (int d = 0; d < 2; d++) m_hexcnt[d] = m_cnt[d];
            if (clr) begin
                m_evt = 0;
                for (int d = 0; d < 2; d++) begin
                    m_cnt[d] = 0; m_ovf[d] = 0;
                end
            end else if (rise && en) begin
                m_evt = 1;
                for (int d = 0; d < 2; d++) begin
                    nxt = m_cnt[d] + (dir ? -1 : 1);
                    if (nxt < 0 || nxt > 255) begin
                        m_ovf[d] = 1;
                        if (d == 0) m_cnt[d] = (nxt + 256) % 256;
                    end else begin
                        m_cnt[d] = nxt;
                    end
                end
            end else begin
                m_evt = 0;
            end
            m_lvlq = lvl;
            m_pop  = $countones(sw);
            if (en) m_led = sw;
        end
    endtask

    task automatic compare_all();
        logic [13:0] exp_hex;
        for (int d = 0; d < 2; d++) begin
            exp_hex = {seg_tab[(m_hexcnt[d] >> 4) & 15], seg_tab[m_hexcnt[d] & 15]};
            check($sformatf("model_count[%0d]", d), cnt[d], m_cnt[d]);
            check($sformatf("model_event[%0d]", d), evt[d], m_evt);
            check($sformatf("model_ovf[%0d]", d), ovf[d], m_ovf[d]);
            check($sformatf("model_ledr[%0d]", d), ledr[d], m_led);
            check($sformatf("model_hex[%0d]", d), hex[d], exp_hex);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Generate events until the count reaches target, then settle with enable off.
    task automatic run_until(input int target);
        en = 1'b1; clr = 1'b0; dir = 1'b0;
        for (int i = 0; i < 1200 && m_cnt[0] != target; i++) begin
            sw = (sw == 10'h000) ? 10'h3FF : 10'h000;
            tick();
        end
        en = 1'b0; sw = 10'h000;
        repeat (3) tick();
        check("preload_count", cnt[0], target);
        en = 1'b1;
    endtask

    initial begin
        // Reset with all switches up.
        @(negedge clk);
        tick();
        tick();
        check("reset_count", cnt[0], 0);
        check("reset_event", evt[0], 0);
        check("reset_ovf", ovf[0], 0);
        check("reset_ledr", ledr[0], 0);
        check("reset_hex", hex[0], 14'h2040);
        check("reset_hex_sat", hex[1], 14'h2040);

        // Release: one event two cycles later.
        arst = 1'b0;
        tick();
        check("release_e1_event", evt[0], 0);
        tick();
        check("release_e2_event", evt[0], 1);
        check("release_e2_count", cnt[0], 1);
        tick();
        check("release_e3_event", evt[0], 0);
        check("release_e3_hex", hex[0], 14'h2079);

        // Threshold boundary table (thresh=3).
        vecs.push_back(mk(10'h007, 1'b1, 0, 1'b0));
        vecs.push_back(mk(10'h007, 1'b0, 0, 1'b0));
        vecs.push_back(mk(10'h007, 1'b0, 0, 1'b0));
        vecs.push_back(mk(10'h00F, 1'b0, 0, 1'b0));
        vecs.push_back(mk(10'h00F, 1'b0, 1, 1'b1));
        for (int i = 0; i < 20; i++) vecs.push_back(mk(10'h00F, 1'b0, 1, 1'b0));
        vecs.push_back(mk(10'h001, 1'b0, 1, 1'b0));
        vecs.push_back(mk(10'h001, 1'b0, 1, 1'b0));
        vecs.push_back(mk(10'h00F, 1'b0, 1, 1'b0));
        vecs.push_back(mk(10'h00F, 1'b0, 2, 1'b1));
        vecs.push_back(mk(10'h00F, 1'b0, 2, 1'b0));
        foreach (vecs[i]) begin
            sw = vecs[i].sw; thr = vecs[i].thr; en = vecs[i].en; clr = vecs[i].clr; dir = 1'b0;
            tick();
            check($sformatf("vec%0d_count", i), cnt[0], vecs[i].exp_cnt);
            check($sformatf("vec%0d_count_sat", i), cnt[1], vecs[i].exp_cnt);
            check($sformatf("vec%0d_event", i), evt[0], vecs[i].exp_evt);
        end
        clr = 1'b0;

        // Enable gating: rises lost while disabled, LEDs hold.
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 10'h000 : 10'h3FF;
            tick();
        end
        check("gated_count", cnt[0], 2);
        check("gated_ledr", ledr[0], 10'h00F);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 10'h000 : 10'h3FF;
            tick();
        end
        check("enabled_count", cnt[0], 7);
        check("enabled_ledr", ledr[0], 10'h3FF);

        // Wrap vs saturate at the top.
        run_until(255);
        sw = 10'h3FF; dir = 1'b0;
        tick();
        tick();
        check("up_limit_event", evt[0], 1);
        check("up_wrap_count", cnt[0], 8'h00);
        check("up_wrap_ovf", ovf[0], 1);
        check("up_sat_count", cnt[1], 8'hFF);
        check("up_sat_ovf", ovf[1], 1);
        sw = 10'h000;
        tick();
        tick();
        check("ovf_sticky", ovf[0], 1);

        // Wrap vs saturate at the bottom, from a cleared counter.
        clr = 1'b1;
        tick();
        check("clr_ovf_wrap", ovf[0], 0);
        check("clr_ovf_sat", ovf[1], 0);
        check("clr_count_sat", cnt[1], 0);
        clr = 1'b0; dir = 1'b1; sw = 10'h3FF;
        tick();
        tick();
        check("down_wrap_count", cnt[0], 8'hFF);
        check("down_wrap_ovf", ovf[0], 1);
        check("down_sat_count", cnt[1], 8'h00);
        check("down_sat_ovf", ovf[1], 1);
        dir = 1'b0; sw = 10'h000;
        tick();
        tick();

        // Clear wins over a simultaneous rise.
        sw = 10'h3FF;
        tick();
        clr = 1'b1;
        tick();
        check("clrprio_count", cnt[0], 0);
        check("clrprio_ovf", ovf[0], 0);
        check("clrprio_event", evt[0], 0);
        clr = 1'b0; sw = 10'h000;
        tick();
        tick();
        sw = 10'h3FF;
        tick();
        tick();
        check("after_clr_count", cnt[0], 1);
        check("after_clr_event", evt[0], 1);

        // Digit mapping for 0xA5.
        run_until(8'hA5);
        check("digit0_seg", hex[0][6:0], 7'b0010010);
        check("digit1_seg", hex[0][13:7], 7'b0001000);

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            sw   = 10'($urandom);
            thr  = 4'($urandom_range(0, 12));
            en   = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 40) == 0);
            dir  = 1'($urandom_range(0, 1));
            arst = ($urandom_range(0, 150) == 0);
            tick();
        end
        arst = 1'b0; clr = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
